// File: rtl/ber_pkg.sv
// Shared types and constants for the BER test sequencer.
// The BER_ERR_INJECT_EN build option lives in ber_test_ctrl.
package ber_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESEED,
        SYNC,
        RUN,
        DONE
    } ber_state_t;

    localparam int ERR_BITS_W = 6;
    localparam logic [3:0] BYTE_ALL = 4'hF;

endpackage

// File: rtl/ber_sat_acc.sv
// Saturating accumulator with synchronous clear and a sticky saturation flag.
// The sum is formed one bit wider than the counter to catch overflow.
module ber_sat_acc
    import ber_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int ADD_W = ERR_BITS_W
) (
    input  logic             clk_in,
    input  logic             arst_in,
    input  logic             clr_in,
    input  logic             add_en_in,
    input  logic [ADD_W-1:0] add_val_in,
    output logic [CNT_W-1:0] acc_out,
    output logic             sat_out
);

    localparam int PAD_W = CNT_W + 1 - ADD_W;

    logic [CNT_W-1:0] acc_q;
    logic             sat_q;
    logic [CNT_W:0]   sum_w;

    assign sum_w = {1'b0, acc_q} + {{PAD_W{1'b0}}, add_val_in};

    always_ff @(posedge clk_in or posedge arst_in) begin
        if (arst_in) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (clr_in) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (add_en_in) begin
            if (sum_w[CNT_W]) begin
                acc_q <= '1;
                sat_q <= 1'b1;
            end else begin
                acc_q <= sum_w[CNT_W-1:0];
            end
        end
    end

    assign acc_out = acc_q;
    assign sat_out = sat_q;

endmodule

// File: rtl/ber_test_ctrl.sv
// BER test run sequencer: reseed, sync/lock, counted run, done.
// Define BER_ERR_INJECT_EN to add the tx error-injection port set.
module ber_test_ctrl
    import ber_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int LOCK_THRESH  = 16,
    parameter int SYNC_TIMEOUT = 4096
) (
    input  logic                  clk_in,
    input  logic                  arst_in,
    input  logic                  start_in,
    input  logic                  abort_in,
    input  logic [CNT_W-1:0]      test_len_in,
    input  logic                  gen_ready_in,
    output logic [3:0]            byte_ctrl_out,
    output logic                  prbs_rst_out,
    input  logic                  rx_valid_in,
    input  logic [ERR_BITS_W-1:0] rx_err_bits_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  locked_out,
    output logic                  lock_fail_out,
    output logic [CNT_W-1:0]      word_cnt_out,
    output logic [CNT_W-1:0]      err_cnt_out,
`ifdef BER_ERR_INJECT_EN
    input  logic                  inject_in,
    output logic                  inject_out,
    output logic [CNT_W-1:0]      inj_cnt_out,
`endif
    output logic                  sat_out
);

    localparam int GOOD_W = $clog2(LOCK_THRESH + 1);
    localparam int TO_W   = $clog2(SYNC_TIMEOUT);
    localparam logic [GOOD_W-1:0] LOCK_V = GOOD_W'(LOCK_THRESH);
    localparam logic [TO_W-1:0]   TO_MAX = TO_W'(SYNC_TIMEOUT - 1);

    ber_state_t        state_q;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  word_q;
    logic [GOOD_W-1:0] good_q;
    logic [GOOD_W-1:0] good_d;
    logic [TO_W-1:0]   to_q;
    logic              locked_q;
    logic              fail_q;
    logic              busy_q;
    logic              done_q;
    logic              prbs_q;

    logic start_ok;
    logic acc_add;
    logic lock_hit;
    logic run_last;
    logic active;

    always_comb begin
        good_d = good_q;
        if (rx_valid_in) begin
            good_d = (rx_err_bits_in == '0) ? good_q + 1'b1 : '0;
        end
    end

    assign start_ok = !abort_in && start_in &&
                      (state_q == IDLE || state_q == DONE);
    assign acc_add  = !abort_in && state_q == RUN && rx_valid_in;
    assign lock_hit = good_d == LOCK_V;
    assign run_last = rx_valid_in && (word_q + 1'b1 == len_q);
    assign active   = state_q == SYNC || state_q == RUN;

    // Abort must silence the generator in the same cycle it is raised.
    assign byte_ctrl_out = (!abort_in && active && gen_ready_in) ?
                           BYTE_ALL : 4'h0;

    always_ff @(posedge clk_in or posedge arst_in) begin
        if (arst_in) begin
            state_q  <= IDLE;
            len_q    <= '0;
            word_q   <= '0;
            good_q   <= '0;
            to_q     <= '0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            prbs_q   <= 1'b0;
        end else if (abort_in) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prbs_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_in) begin
                        state_q  <= RESEED;
                        len_q    <= test_len_in;
                        word_q   <= '0;
                        locked_q <= 1'b0;
                        fail_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        prbs_q   <= 1'b1;
                    end
                end
                RESEED: begin
                    state_q <= SYNC;
                    good_q  <= '0;
                    to_q    <= '0;
                    prbs_q  <= 1'b0;
                end
                SYNC: begin
                    good_q <= good_d;
                    to_q   <= to_q + 1'b1;
                    if (lock_hit) begin
                        locked_q <= 1'b1;
                        if (len_q == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end else if (to_q == TO_MAX) begin
                        fail_q  <= 1'b1;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (rx_valid_in) begin
                        word_q <= word_q + 1'b1;
                    end
                    if (run_last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    prbs_q  <= 1'b0;
                end
            endcase
        end
    end

    ber_sat_acc #(
        .CNT_W (CNT_W),
        .ADD_W (ERR_BITS_W)
    ) u_err_acc (
        .clk_in     (clk_in),
        .arst_in    (arst_in),
        .clr_in     (start_ok),
        .add_en_in  (acc_add),
        .add_val_in (rx_err_bits_in),
        .acc_out    (err_cnt_out),
        .sat_out    (sat_out)
    );

`ifdef BER_ERR_INJECT_EN
    logic             pend_q;
    logic [CNT_W-1:0] inj_q;

    assign inject_out  = pend_q && byte_ctrl_out == BYTE_ALL;
    assign inj_cnt_out = inj_q;

    // A request waits for an accepted tx word so the flip is never lost.
    always_ff @(posedge clk_in or posedge arst_in) begin
        if (arst_in) begin
            pend_q <= 1'b0;
            inj_q  <= '0;
        end else if (start_ok || abort_in) begin
            pend_q <= 1'b0;
            if (start_ok) begin
                inj_q <= '0;
            end
        end else begin
            if (inject_out) begin
                pend_q <= 1'b0;
                inj_q  <= inj_q + 1'b1;
            end
            if (inject_in && state_q == RUN) begin
                pend_q <= 1'b1;
            end
        end
    end
`endif

    assign prbs_rst_out  = prbs_q;
    assign busy_out      = busy_q;
    assign done_out      = done_q;
    assign locked_out    = locked_q;
    assign lock_fail_out = fail_q;
    assign word_cnt_out  = word_q;

endmodule

// File: tb/tb_ber_test_ctrl.sv
// Directed bench for ber_test_ctrl, default and 8-bit counter builds.
module tb_ber_test_ctrl;

    logic        clk = 1'b0;
    logic        arst;
    logic        start;
    logic        abort;
    logic [31:0] test_len;
    logic [7:0]  len8;
    logic        gen_ready;
    logic        rx_valid;
    logic [5:0]  rx_err;

    logic [3:0]  byte_ctrl;
    logic        prbs_rst;
    logic        busy;
    logic        done;
    logic        locked;
    logic        lock_fail;
    logic [31:0] word_cnt;
    logic [31:0] err_cnt;
    logic        sat;

    logic [3:0]  byte8;
    logic        prbs8;
    logic        busy8;
    logic        done8;
    logic        locked8;
    logic        fail8;
    logic [7:0]  word8;
    logic [7:0]  err8;
    logic        sat8;

    int checks = 0;
    int failures = 0;
    int prbs_pulses = 0;
    int p0;

    always #5 clk = ~clk;

    assign len8 = test_len[7:0];

    always @(negedge clk) if (prbs_rst === 1'b1) prbs_pulses++;

    ber_test_ctrl u_dut (
        .clk_in         (clk),
        .arst_in        (arst),
        .start_in       (start),
        .abort_in       (abort),
        .test_len_in    (test_len),
        .gen_ready_in   (gen_ready),
        .byte_ctrl_out  (byte_ctrl),
        .prbs_rst_out   (prbs_rst),
        .rx_valid_in    (rx_valid),
        .rx_err_bits_in (rx_err),
        .busy_out       (busy),
        .done_out       (done),
        .locked_out     (locked),
        .lock_fail_out  (lock_fail),
        .word_cnt_out   (word_cnt),
        .err_cnt_out    (err_cnt),
        .sat_out        (sat)
    );

    ber_test_ctrl #(.CNT_W(8)) u_dut8 (
        .clk_in         (clk),
        .arst_in        (arst),
        .start_in       (start),
        .abort_in       (abort),
        .test_len_in    (len8),
        .gen_ready_in   (gen_ready),
        .byte_ctrl_out  (byte8),
        .prbs_rst_out   (prbs8),
        .rx_valid_in    (rx_valid),
        .rx_err_bits_in (rx_err),
        .busy_out       (busy8),
        .done_out       (done8),
        .locked_out     (locked8),
        .lock_fail_out  (fail8),
        .word_cnt_out   (word8),
        .err_cnt_out    (err8),
        .sat_out        (sat8)
    );

    task automatic step(input logic v, input logic [5:0] e);
        rx_valid = v;
        rx_err   = e;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_err   = 6'd0;
    endtask

    // Leaves the DUT in its first SYNC cycle.
    task automatic begin_run(input logic [31:0] len);
        start    = 1'b1;
        test_len = len;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        arst = 1'b1;
        #1;
        checks++;
        if ({busy, done, locked, lock_fail, sat, prbs_rst, byte_ctrl} !== 10'd0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0",
                     {busy, done, locked, lock_fail, sat, prbs_rst, byte_ctrl});
        end
        checks++;
        if ({word_cnt, err_cnt} !== 64'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", word_cnt, err_cnt);
        end
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean_run();
        p0 = prbs_pulses;
        begin_run(32'd100);
        checks++;
        if (prbs_pulses !== p0 + 1) begin
            failures++;
            $display("FAIL reseed_pulse got=%0d exp=%0d", prbs_pulses - p0, 1);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL sync_busy got=%b exp=1", busy);
        end
        repeat (15) step(1'b1, 6'd0);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL lock_early got=%b exp=0", locked);
        end
        step(1'b1, 6'd0);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL lock_16 got=%b exp=1", locked);
        end
        checks++;
        if (byte_ctrl !== 4'hF) begin
            failures++;
            $display("FAIL byte_run got=%h exp=F", byte_ctrl);
        end
        gen_ready = 1'b0;
        #1;
        checks++;
        if (byte_ctrl !== 4'h0) begin
            failures++;
            $display("FAIL byte_noready got=%h exp=0", byte_ctrl);
        end
        gen_ready = 1'b1;
        repeat (50) step(1'b1, 6'd0);
        start = 1'b1;
        step(1'b1, 6'd0);
        start = 1'b0;
        checks++;
        if (word_cnt !== 32'd51) begin
            failures++;
            $display("FAIL start_in_run got=%0d exp=%0d", word_cnt, 51);
        end
        repeat (48) step(1'b1, 6'd0);
        checks++;
        if (done !== 1'b0 || word_cnt !== 32'd99) begin
            failures++;
            $display("FAIL word99 got=%b/%0d exp=0/99", done, word_cnt);
        end
        step(1'b1, 6'd0);
        checks++;
        if ({done, busy} !== 2'b10 || word_cnt !== 32'd100 || err_cnt !== 32'd0) begin
            failures++;
            $display("FAIL clean_done got=%b%b/%0d/%0d exp=10/100/0",
                     done, busy, word_cnt, err_cnt);
        end
        step(1'b1, 6'd1);
        checks++;
        if (word_cnt !== 32'd100 || err_cnt !== 32'd0) begin
            failures++;
            $display("FAIL after_done got=%0d/%0d exp=100/0", word_cnt, err_cnt);
        end
        checks++;
        if (prbs_pulses !== p0 + 1) begin
            failures++;
            $display("FAIL pulse_total got=%0d exp=%0d", prbs_pulses - p0, 1);
        end
    endtask

    task automatic test_err_words();
        begin_run(32'd10);
        checks++;
        if (word_cnt !== 32'd0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL restart_clear got=%0d/%b exp=0/0", word_cnt, locked);
        end
        repeat (16) step(1'b1, 6'd0);
        repeat (10) step(1'b1, 6'd3);
        checks++;
        if (err_cnt !== 32'd30 || word_cnt !== 32'd10 || done !== 1'b1) begin
            failures++;
            $display("FAIL err3 got=%0d/%0d/%b exp=30/10/1", err_cnt, word_cnt, done);
        end
    endtask

    task automatic test_sync_restart();
        begin_run(32'd5);
        repeat (14) step(1'b1, 6'd0);
        step(1'b1, 6'd5);
        repeat (15) step(1'b1, 6'd0);
        step(1'b0, 6'd7);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL relock_30 got=%b exp=0", locked);
        end
        step(1'b1, 6'd0);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL relock_31 got=%b exp=1", locked);
        end
        repeat (5) step(1'b1, 6'd0);
        checks++;
        if (done !== 1'b1 || word_cnt !== 32'd5) begin
            failures++;
            $display("FAIL relock_done got=%b/%0d exp=1/5", done, word_cnt);
        end
    endtask

    task automatic test_timeout();
        begin_run(32'd5);
        repeat (4095) step(1'b0, 6'd0);
        checks++;
        if (busy !== 1'b1 || lock_fail !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early got=%b/%b exp=1/0", busy, lock_fail);
        end
        step(1'b0, 6'd0);
        checks++;
        if ({done, lock_fail, locked} !== 3'b110 || byte_ctrl !== 4'h0) begin
            failures++;
            $display("FAIL timeout got=%b/%h exp=110/0",
                     {done, lock_fail, locked}, byte_ctrl);
        end
    endtask

    task automatic test_sat();
        begin_run(32'd10);
        repeat (16) step(1'b1, 6'd0);
        repeat (7) step(1'b1, 6'd32);
        checks++;
        if (err8 !== 8'd224 || sat8 !== 1'b0) begin
            failures++;
            $display("FAIL sat_w7 got=%0d/%b exp=224/0", err8, sat8);
        end
        step(1'b1, 6'd32);
        checks++;
        if (err8 !== 8'hFF || sat8 !== 1'b1) begin
            failures++;
            $display("FAIL sat_w8 got=%h/%b exp=ff/1", err8, sat8);
        end
        repeat (2) step(1'b1, 6'd32);
        checks++;
        if (err8 !== 8'hFF || sat8 !== 1'b1 || word8 !== 8'd10 || done8 !== 1'b1) begin
            failures++;
            $display("FAIL sat_end got=%h/%b/%0d/%b exp=ff/1/10/1",
                     err8, sat8, word8, done8);
        end
        checks++;
        if (err_cnt !== 32'd320 || sat !== 1'b0) begin
            failures++;
            $display("FAIL wide_err got=%0d/%b exp=320/0", err_cnt, sat);
        end
    endtask

    task automatic test_abort();
        begin_run(32'd20);
        repeat (16) step(1'b1, 6'd0);
        repeat (5) step(1'b1, 6'd0);
        abort    = 1'b1;
        rx_valid = 1'b1;
        #1;
        checks++;
        if (byte_ctrl !== 4'h0) begin
            failures++;
            $display("FAIL abort_byte got=%h exp=0", byte_ctrl);
        end
        @(negedge clk);
        abort    = 1'b0;
        rx_valid = 1'b0;
        checks++;
        if ({busy, done, locked} !== 3'b001 || word_cnt !== 32'd5) begin
            failures++;
            $display("FAIL abort_hold got=%b/%0d exp=001/5", {busy, done, locked}, word_cnt);
        end
        step(1'b1, 6'd0);
        checks++;
        if (word_cnt !== 32'd5 || byte_ctrl !== 4'h0) begin
            failures++;
            $display("FAIL abort_idle got=%0d/%h exp=5/0", word_cnt, byte_ctrl);
        end
    endtask

    task automatic test_arst_mid_run();
        begin_run(32'd20);
        repeat (16) step(1'b1, 6'd0);
        repeat (3) step(1'b1, 6'd2);
        p0 = prbs_pulses;
        #2;
        arst = 1'b1;
        #1;
        checks++;
        if ({busy, done, locked, lock_fail, sat, prbs_rst, byte_ctrl} !== 10'd0 ||
            {word_cnt, err_cnt} !== 64'd0) begin
            failures++;
            $display("FAIL arst_async got=%b/%0d/%0d exp=0/0/0",
                     {busy, done, locked, lock_fail, sat, prbs_rst, byte_ctrl},
                     word_cnt, err_cnt);
        end
        @(negedge clk);
        arst = 1'b0;
        repeat (3) step(1'b1, 6'd0);
        checks++;
        if (prbs_pulses !== p0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL arst_quiet got=%0d/%b exp=0/0", prbs_pulses - p0, busy);
        end
    endtask

    initial begin
        arst      = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        test_len  = 32'd0;
        gen_ready = 1'b1;
        rx_valid  = 1'b0;
        rx_err    = 6'd0;
        test_reset();
        test_clean_run();
        test_err_words();
        test_sync_restart();
        test_timeout();
        test_sat();
        test_abort();
        test_arst_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ber_test_ctrl.md
Name: ber_test_ctrl

Overview:
Sequencer for one BER test run. Reseeds the PRBS generator, advances it under downstream backpressure, and waits for the receive checker to lock. It then counts checked words and bit errors over a programmed test length and reports completion. It sits between the host register interface and the PRBS generator/checker pair.

Parameters:
CNT_W, 32, width of the test-length, word and error counters
LOCK_THRESH, 16, consecutive error-free rx words required to declare lock
SYNC_TIMEOUT, 4096, maximum cycles spent in SYNC before declaring lock failure

Ports:
clk_in  in  1  single clock
arst_in  in  1  asynchronous reset, active-high
start_in  in  1  one-cycle start pulse; sampled only in IDLE or DONE
abort_in  in  1  return to IDLE from any state; has priority over all other inputs
test_len_in  in  CNT_W  number of rx words to check in RUN; latched on start
gen_ready_in  in  1  downstream accepts a tx word this cycle
byte_ctrl_out  out  4  PRBS advance enable; 4'hF or 4'h0
prbs_rst_out  out  1  one-cycle reseed pulse to the generator and checker
rx_valid_in  in  1  checker result valid this cycle
rx_err_bits_in  in  6  bit errors in the current rx word, 0..32
busy_out  out  1  high in RESEED, SYNC and RUN
done_out  out  1  high in DONE
locked_out  out  1  lock achieved during the current or last run
lock_fail_out  out  1  SYNC timed out in the last run
word_cnt_out  out  CNT_W  rx words checked in RUN
err_cnt_out  out  CNT_W  accumulated bit errors, saturating
sat_out  out  1  err_cnt_out has saturated

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Counters and flags are 0.
- States: IDLE, RESEED, SYNC, RUN, DONE. All state transitions are registered.
- IDLE or DONE, with start_in=1:
  - Clear the counters, locked_out, lock_fail_out and sat_out.
  - Latch test_len_in.
  - Go to RESEED.
- RESEED:
  - Lasts exactly 1 cycle with prbs_rst_out=1.
  - Then go to SYNC and clear the good-run and timeout counters.
- byte_ctrl_out:
  - Combinational.
  - Equals 4'hF when state is SYNC or RUN and gen_ready_in=1; else 4'h0.
- SYNC:
  - Each rx_valid_in with rx_err_bits_in=0 increments the good-run counter.
  - Each rx_valid_in with a nonzero error count resets the good-run counter to 0.
  - When the good-run counter reaches LOCK_THRESH: set locked_out and go to RUN, or to DONE if the latched length is 0.
  - The timeout counter increments every cycle. When it reaches SYNC_TIMEOUT-1 without lock: set lock_fail_out and go to DONE.
  - Lock and timeout on the same cycle: lock wins.
- RUN:
  - Each rx_valid_in increments word_cnt_out.
  - Each rx_valid_in adds rx_err_bits_in to err_cnt_out.
  - When word_cnt_out reaches the latched length (word N counted), go to DONE on the next edge.
  - rx words after that edge are ignored.
- Error counter saturation:
  - The sum is computed CNT_W+1 wide.
  - On overflow, err_cnt_out=all-ones and sat_out=1 (sticky).
- DONE:
  - Counters and flags hold.
  - start_in re-arms the run.
- abort_in=1 in any state: go to IDLE next cycle.
  - Counters and flags hold for readout.
  - byte_ctrl_out drops to 0 in the same cycle (combinational on abort).
- start_in outside IDLE/DONE is ignored.
- arst_in mid-run: immediate return to reset values. No reseed pulse is emitted.

Optional Feature:
BER_ERR_INJECT_EN
- Defined:
  - Adds input inject_in (1) and output inject_out (1).
  - A pulse on inject_in in RUN is held pending until the next cycle with byte_ctrl_out=4'hF.
  - inject_out is asserted on that cycle (one cycle) to flip tx bit 0.
  - Adds output inj_cnt_out (CNT_W), counting injections; cleared on start.
- Undefined: none of these ports exist. Behaviour is otherwise identical.

Decomposition:
- Package ber_pkg:
  - State enum ber_state_t (IDLE, RESEED, SYNC, RUN, DONE).
  - Constant ERR_BITS_W=6.
  - Constant BYTE_ALL=4'hF.
- One natural sub-module: ber_sat_acc. It is a saturating CNT_W accumulator with clear, add-enable and add-value inputs, and a sticky sat flag. It is used for err_cnt_out.

Test Plan:
- test_len=100, LOCK_THRESH=16, clean rx:
  - prbs_rst_out pulses once.
  - locked_out rises after the 16th valid word.
  - Exactly 100 words counted; err_cnt=0; done_out=1.
- test_len=10, rx_err_bits=3 on every RUN word: err_cnt_out=30, word_cnt_out=10.
- One error on word 15 of SYNC: the good-run counter restarts, so lock requires 16 more clean words (lock at valid word 31).
- No valid rx for 4096 cycles in SYNC: lock_fail_out=1, locked_out=0, state DONE, byte_ctrl_out=0.
- CNT_W=8, err=32 per word, test_len=10: sat_out=1 and err_cnt_out=8'hFF after the 8th word.
- abort_in mid-RUN at word 5: IDLE next cycle, byte_ctrl_out=0, word_cnt_out holds 5.
- arst_in mid-RUN: all outputs 0 asynchronously.
